// File: rtl/dsp_cascade_add_ctrl.sv
// Valid/ready flow controller for a 2-DSP SIMD INT9xUINT8 cascade multiply-add pair.
// Optional stall/beat counters are built when DSP_CASCADE_CTRL_STATS_EN is defined.
module dsp_cascade_add_ctrl #(
    parameter int DSP_LATENCY = 5,
    parameter int FIFO_DEPTH  = 8,
    parameter int LANE_SHIFT  = 18
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_a0,
    input  logic [7:0]  s_b0,
    input  logic [7:0]  s_a1,
    input  logic [7:0]  s_b1,
    input  logic [8:0]  s_coeff0,
    input  logic [8:0]  s_coeff1,
    output logic [7:0]  dsp_a0,
    output logic [7:0]  dsp_b0,
    output logic [7:0]  dsp_a1,
    output logic [7:0]  dsp_b1,
    output logic [8:0]  dsp_coeff0,
    output logic [8:0]  dsp_coeff1,
    output logic        dsp_clken,
    output logic        dsp_reset,
    input  logic [47:0] dsp_dout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [17:0] m_lane0,
`ifdef DSP_CASCADE_CTRL_STATS_EN
    output logic [31:0] stat_beats,
    output logic [31:0] stat_stall,
`endif
    output logic [17:0] m_lane1
);

    localparam int LAT_W = (DSP_LATENCY > 1) ? $clog2(DSP_LATENCY) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FLUSH,
        ST_RUN
    } state_t;

    state_t                   state;
    logic [LAT_W-1:0]         cnt;
    logic [DSP_LATENCY-1:0]   vld_pipe;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W:0]           credit_used;
    logic [CNT_W-1:0]         fifo_cnt;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [35:0]              fifo_mem [FIFO_DEPTH];
    logic                     s_fire;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic [17:0]              wr_lane0;
    logic [17:0]              wr_lane1;
    logic                     unused_dout_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign dsp_a0     = s_a0;
    assign dsp_b0     = s_b0;
    assign dsp_a1     = s_a1;
    assign dsp_b1     = s_b1;
    assign dsp_coeff0 = s_coeff0;
    assign dsp_coeff1 = s_coeff1;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < DSP_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld_pipe[i]);
        end
    end

    // Credits cover both buffered and in-flight beats, so the FIFO cannot overflow.
    assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight};
    assign s_ready     = (state == ST_RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign s_fire      = s_valid && s_ready;
    assign dsp_clken   = (state != ST_RUN) || s_fire || (|vld_pipe);

    assign push      = dsp_clken && vld_pipe[DSP_LATENCY-1];
    assign m_valid   = (fifo_cnt != '0);
    assign pop       = m_valid && m_ready;
    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));

    // The low lane is sign-extended into the high lane by the cascade, so add its sign back.
    assign wr_lane0         = dsp_dout[17:0];
    assign wr_lane1         = dsp_dout[LANE_SHIFT+17:LANE_SHIFT] + {17'd0, dsp_dout[17]};
    assign unused_dout_bits = ^dsp_dout[47:LANE_SHIFT+18];

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_INIT;
            cnt       <= '0;
            dsp_reset <= 1'b1;
        end else begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (cnt == LAT_W'(DSP_LATENCY - 1)) begin
                        state     <= ST_RUN;
                        cnt       <= '0;
                        dsp_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + LAT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state     <= ST_FLUSH;
                        cnt       <= '0;
                        dsp_reset <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    cnt       <= '0;
                    dsp_reset <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (dsp_clken) begin
                vld_pipe <= {vld_pipe[DSP_LATENCY-2:0], s_fire};
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // NOTE: the FIFO storage has no reset; fifo_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_lane1, wr_lane0};
        end
    end

    assign m_lane0 = fifo_mem[rd_ptr][17:0];
    assign m_lane1 = fifo_mem[rd_ptr][35:18];

    a_fifo_no_overflow: assert property (
        @(posedge clk) disable iff (!aresetn) !(push && !pop && fifo_full && !flush)
    );

`ifdef DSP_CASCADE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else if (flush) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (pop && (stat_beats != '1)) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if ((state == ST_RUN) && s_valid && !s_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_cascade_add_ctrl.sv
// Self-checking bench for dsp_cascade_add_ctrl: behavioural DSP pair plus a beat-level
// scoreboard predicting handshake, clock-enable, reset and output lane values.
module tb_dsp_cascade_add_ctrl;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_a0, s_b0, s_a1, s_b1;
    logic [8:0]  s_coeff0, s_coeff1;
    logic [7:0]  dsp_a0, dsp_b0, dsp_a1, dsp_b1;
    logic [8:0]  dsp_coeff0, dsp_coeff1;
    logic        dsp_clken;
    logic        dsp_reset;
    logic [47:0] dsp_dout;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_lane0, m_lane1;
`ifdef DSP_CASCADE_CTRL_STATS_EN
    logic [31:0] stat_beats, stat_stall;
`endif

    always #5 clk = ~clk;

    dsp_cascade_add_ctrl dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a0       (s_a0),
        .s_b0       (s_b0),
        .s_a1       (s_a1),
        .s_b1       (s_b1),
        .s_coeff0   (s_coeff0),
        .s_coeff1   (s_coeff1),
        .dsp_a0     (dsp_a0),
        .dsp_b0     (dsp_b0),
        .dsp_a1     (dsp_a1),
        .dsp_b1     (dsp_b1),
        .dsp_coeff0 (dsp_coeff0),
        .dsp_coeff1 (dsp_coeff1),
        .dsp_clken  (dsp_clken),
        .dsp_reset  (dsp_reset),
        .dsp_dout   (dsp_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_lane0    (m_lane0),
`ifdef DSP_CASCADE_CTRL_STATS_EN
        .stat_beats (stat_beats),
        .stat_stall (stat_stall),
`endif
        .m_lane1    (m_lane1)
    );

    // Behavioural DSP pair: packed two-lane sum, 5 clock-enabled stages, synchronous reset.
    logic [47:0] dsp_pipe [LAT];

    function automatic logic [47:0] dsp_pack(input logic [7:0] a0, b0, a1, b1,
                                             input logic [8:0] c0, c1);
        longint l0, l1, p;
        l0 = longint'(a0) * longint'($signed(c0)) + longint'(a1) * longint'($signed(c1));
        l1 = longint'(b0) * longint'($signed(c0)) + longint'(b1) * longint'($signed(c1));
        p  = l0 + l1 * 64'sd262144;
        return p[47:0];
    endfunction

    always @(posedge clk) begin
        if (dsp_reset) begin
            for (int i = 0; i < LAT; i++) dsp_pipe[i] <= '0;
        end else if (dsp_clken) begin
            dsp_pipe[0] <= dsp_pack(dsp_a0, dsp_b0, dsp_a1, dsp_b1, dsp_coeff0, dsp_coeff1);
            for (int i = 1; i < LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
        end
    end
    assign dsp_dout = dsp_pipe[LAT-1];

    // Scoreboard: accepted beats not yet taken downstream, with the cycle they become visible.
    typedef struct {
        logic [17:0] lane0;
        logic [17:0] lane1;
        int          avail;
    } beat_t;

    beat_t sb[$];
    int    cyc;
    int    run_start;
    int    n_checks;
    int    n_pass;
    int    n_pops;
    bit    fired;

    function automatic logic [17:0] exp_lane(input logic [7:0] x0, x1, input logic [8:0] c0, c1);
        int s;
        s = int'(x0) * int'($signed(c0)) + int'(x1) * int'($signed(c1));
        return s[17:0];
    endfunction

    function automatic bit pending();
        foreach (sb[i]) if (sb[i].avail > cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        logic  run, exp_ready, exp_mv, exp_clken;
        beat_t nb;
        run = (cyc >= run_start);
        #1;
        exp_ready = run && (sb.size() < DEPTH);
        fired     = s_valid && exp_ready;
        exp_mv    = 1'b0;
        if (sb.size() > 0) exp_mv = (sb[0].avail <= cyc);
        exp_clken = !run || fired || pending();
        check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
        check("dsp_reset", {31'd0, dsp_reset}, {31'd0, !run});
        check("dsp_clken", {31'd0, dsp_clken}, {31'd0, exp_clken});
        check("m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
        if (exp_mv) begin
            check("m_lane0", {14'd0, m_lane0}, {14'd0, sb[0].lane0});
            check("m_lane1", {14'd0, m_lane1}, {14'd0, sb[0].lane1});
        end
        if (m_valid === 1'b1 && m_ready) n_pops++;
        nb.lane0 = exp_lane(s_a0, s_a1, s_coeff0, s_coeff1);
        nb.lane1 = exp_lane(s_b0, s_b1, s_coeff0, s_coeff1);
        nb.avail = cyc + LAT + 1;
        @(posedge clk);
        if (flush) begin
            sb.delete();
            run_start = cyc + LAT + 1;
        end else begin
            if (exp_mv && m_ready) void'(sb.pop_front());
            if (fired) sb.push_back(nb);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [7:0] a0, b0, a1, b1, input logic [8:0] c0, c1);
        s_a0 = a0; s_b0 = b0; s_a1 = a1; s_b1 = b1; s_coeff0 = c0; s_coeff1 = c1;
    endtask

    task automatic rand_beat();
        set_beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 9'($urandom), 9'($urandom));
    endtask

    task automatic release_reset();
        aresetn   = 1'b1;
        cyc       = 0;
        run_start = LAT;
        sb.delete();
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int g = 0; g < 64 && sb.size() > 0; g++) tick();
        #1;
        check("drain_m_valid", {31'd0, m_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fire_cyc, acc, pops0;
        n_checks = 0; n_pass = 0; n_pops = 0; cyc = 0; run_start = LAT;
        aresetn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        set_beat(0, 0, 0, 0, 0, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_dsp_reset", {31'd0, dsp_reset}, 32'd1);
        check("rst_dsp_clken", {31'd0, dsp_clken}, 32'd1);
        @(negedge clk);
        release_reset();

        // First beat offered from reset release: accepted after the 5-cycle INIT.
        set_beat(8'd10, 8'd20, 8'd5, 8'd7, 9'd3, 9'(-2));
        s_valid = 1'b1; m_ready = 1'b1;
        fire_cyc = -1;
        for (int g = 0; g < 20 && fire_cyc < 0; g++) begin
            tick();
            if (fired) fire_cyc = cyc - 1;
        end
        check("init_fire_cycle", 32'(fire_cyc), 32'd5);
        s_valid = 1'b0;
        repeat (LAT) tick();
        #1;
        check("beat1_valid", {31'd0, m_valid}, 32'd1);
        check("beat1_lane0", {14'd0, m_lane0}, 32'd20);
        check("beat1_lane1", {14'd0, m_lane1}, 32'd46);
        tick();

        // Borrow-correction corner.
        set_beat(8'd255, 8'd255, 8'd255, 8'd0, 9'(-256), 9'(-256));
        s_valid = 1'b1;
        tick();
        check("beat2_fired", {31'd0, fired}, 32'd1);
        s_valid = 1'b0;
        repeat (LAT) tick();
        #1;
        check("beat2_valid", {31'd0, m_valid}, 32'd1);
        check("beat2_lane0", {14'd0, m_lane0}, {14'd0, 18'(-130560)});
        check("beat2_lane1", {14'd0, m_lane1}, {14'd0, 18'(-65280)});
        tick();

        // Idle pipeline gates the DSP clock; the next fire re-enables it at once.
        repeat (10) tick();
        #1;
        check("idle_clken", {31'd0, dsp_clken}, 32'd0);
        rand_beat();
        s_valid = 1'b1;
        #1;
        check("fire_clken", {31'd0, dsp_clken}, 32'd1);
        tick();
        drain();

        // Backpressure: only FIFO_DEPTH beats accepted, then all 20 delivered in order.
        m_ready = 1'b0; s_valid = 1'b1; acc = 0; pops0 = n_pops;
        for (int i = 0; i < 20; i++) begin
            rand_beat();
            tick();
            if (s_valid && s_ready === 1'b1) acc = acc;
            if (fired) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd8);
        #1;
        check("bp_s_ready", {31'd0, s_ready}, 32'd0);
        m_ready = 1'b1;
        for (int g = 0; g < 200 && acc < 20; g++) begin
            rand_beat();
            tick();
            if (fired) acc++;
        end
        drain();
        check("bp_out_count", 32'(n_pops - pops0), 32'd20);

        // Flush with 3 in flight and 2 buffered; only the post-flush beat emerges.
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            tick();
        end
        s_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_m_valid", {31'd0, m_valid}, 32'd0);
        check("flush_dsp_reset", {31'd0, dsp_reset}, 32'd1);
        pops0 = n_pops;
        rand_beat();
        s_valid = 1'b1; m_ready = 1'b1;
        for (int g = 0; g < 20; g++) begin
            tick();
            if (fired) break;
        end
        s_valid = 1'b0;
        repeat (10) tick();
        check("flush_out_count", 32'(n_pops - pops0), 32'd1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rand_beat();
            flush   = ($urandom_range(0, 63) == 0);
            s_valid = !flush && ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        flush = 1'b0;
        drain();

        // Asynchronous reset mid-operation loses everything and re-runs INIT.
        s_valid = 1'b1; m_ready = 1'b0;
        repeat (4) begin
            rand_beat();
            tick();
        end
        aresetn = 1'b0;
        #1;
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_dsp_reset", {31'd0, dsp_reset}, 32'd1);
        repeat (2) @(negedge clk);
        release_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rand_beat();
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
